idu_regfile_sb: RTL and testbench
=================================

# idu_regfile_sb

Parametrised register-file and writeback unit for the hxd32 instruction decode stage. It has a configurable number of registers and read ports, an internal writeback source mux, write-to-read bypass, and a per-register pending-write scoreboard. Decode uses the scoreboard to stall on long-latency (DRAM load) results. The block sits between decode, which supplies addresses, issue and read-enables, and the execute/memory stages, which supply ALU, DRAM and PC-next results.

## Interface

Parameters:

- XLEN, 32, data width.
- NREG, 32, number of architectural registers; 16 (RV32E) or 32.
- RD_PORTS, 2, number of read ports, 1..4.
- PEND_W, 2, width of per-register pending counter; max outstanding writes per register = 2^PEND_W-1.

Ports:

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- rs_rd_en_i  in  RD_PORTS  port p operand is used this cycle (qualifies stall).
- rs_rd_addr_i  in  RD_PORTS*5  port p read address, bits [5p+4:5p].
- rs_rd_data_o  out  RD_PORTS*XLEN  port p read data.
- rs_busy_o  out  RD_PORTS  port p register has a pending write after this cycle's completion.
- stall_o  out  1  OR over p of (rs_rd_en_i[p] & rs_busy_o[p]).
- issue_en_i  in  1  a long-latency write to issue_addr_i is launched.
- issue_addr_i  in  5  destination of the issued write.
- issue_ready_o  out  1  pending counter of issue_addr_i is not saturated.
- rd_wr_en_i  in  1  writeback enable.
- rd_wr_sel_i  in  2  source: 0 ALU, 1 DRAM, 2 PC_NEXT, 3 none (data 0).
- rd_wr_addr_i  in  5  writeback destination.
- alu_data_i, dram_data_i, pc_next_i  in  XLEN each  writeback sources.
- err_o  out  1  one-cycle pulse on a protocol error (see Operation).

## Operation

- Writeback data is mux(rd_wr_sel_i) of the sources; sel 3 gives 0.
- A write is effective when rd_wr_en_i=1, rd_wr_addr_i!=0 and rd_wr_addr_i<NREG. The register is updated at the clock edge.
- Reads are combinational. Address 0 or address >=NREG returns 0.
- Bypass: if an effective write targets a port's address in the same cycle, that port returns the writeback data, not the stored value.
- Scoreboard: one PEND_W-bit counter per register, index 1..NREG-1. x0 has no counter and is never busy.
- Increment: issue_en_i=1 & issue_ready_o=1 & addr!=0 & addr<NREG.
- Decrement (completion): effective write with rd_wr_sel_i=1 and the target counter !=0.
- Increment and decrement of the same register in one cycle leave the counter unchanged.
- rs_busy_o[p] = (cnt[addr_p] - dec_this_cycle_for_addr_p) != 0. A completing load therefore unstalls its consumer in the same cycle, with bypassed data.
- issue_ready_o = cnt[issue_addr_i] != all-ones. For addr 0 or >=NREG, issue_ready_o=1 and no count is taken.
- err_o pulses the cycle after any of these:
  - issue_en_i while issue_ready_o=0 (issue dropped);
  - DRAM-sel effective write to a register whose counter is 0 (data still written);
  - any enabled write or issue to an address >=NREG.
- ALU/PC_NEXT writes never touch the counters.

## Timing

- Read path, bypass, rs_busy_o, stall_o and issue_ready_o are combinational, zero latency.
- Register array, counters and err_o update on the rising edge; the new values are visible in the next cycle.
- Reset (rst_i=1 at an edge): all registers 0, all counters 0, err_o=0. While rst_i is asserted, writes and issues are ignored. During reset, outputs are: rs_rd_data_o 0 (bypass disabled), rs_busy_o 0, stall_o 0, issue_ready_o 1.
- Reset asserted mid-operation discards all outstanding pending counts. Completions arriving after reset are flagged on err_o and their data is written.
- Counter saturation: after 2^PEND_W-1 increments without a completion, issue_ready_o=0. Counters never wrap.

## Test plan

- Reset, then write x5=0xDEADBEEF (sel 0), then read x5 on both ports the next cycle -> 0xDEADBEEF. Write to x0 -> x0 reads 0.
- Write x7=0x12345678 (sel 2, pc_next) while port 1 reads x7 in the same cycle -> port 1 returns 0x12345678 combinationally.
- Issue x3; next cycle rs_rd_en_i[0]=1 on x3 -> rs_busy_o[0]=1, stall_o=1. DRAM write x3=0xA5A5A5A5 -> same cycle busy=0, stall_o=0, data 0xA5A5A5A5.
- PEND_W=2: issue x9 three times -> issue_ready_o=0; a fourth issue -> err_o pulse and the counter stays 3. Three DRAM completions -> busy drops only after the third.
- Issue and DRAM-complete x4 in the same cycle with counter=1 -> counter stays 1, busy remains 1. DRAM write to idle x6 -> data written, err_o pulse.
- NREG=16: write x20 -> err_o pulse, read x20=0. Assert rst_i with x3 pending -> counters cleared, stall_o=0.

Source files
------------

// File: rtl/idu_regfile_sb.sv
// idu_regfile_sb: hxd32 decode register file with internal writeback source mux,
// write-to-read bypass and a per-register pending-write scoreboard that decode
// uses to stall on outstanding long-latency (DRAM load) results.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   rs_rd_en_i/addr_i, rs_rd_data_o   per-port operand enable, address, read data
//   rs_busy_o, stall_o                per-port pending flag, decode stall
//   issue_en_i/addr_i, issue_ready_o  long-latency write launch and acceptance
//   rd_wr_en_i/sel_i/addr_i           writeback enable, source select, destination
//   alu_data_i, dram_data_i, pc_next_i writeback sources
//   err_o                             registered one-cycle protocol error pulse
module idu_regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned PEND_W   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [RD_PORTS-1:0]      rs_rd_en_i,
    input  logic [RD_PORTS*5-1:0]    rs_rd_addr_i,
    output logic [RD_PORTS*XLEN-1:0] rs_rd_data_o,
    output logic [RD_PORTS-1:0]      rs_busy_o,
    output logic                     stall_o,
    input  logic                     issue_en_i,
    input  logic [4:0]               issue_addr_i,
    output logic                     issue_ready_o,
    input  logic                     rd_wr_en_i,
    input  logic [1:0]               rd_wr_sel_i,
    input  logic [4:0]               rd_wr_addr_i,
    input  logic [XLEN-1:0]          alu_data_i,
    input  logic [XLEN-1:0]          dram_data_i,
    input  logic [XLEN-1:0]          pc_next_i,
    output logic                     err_o
);

    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]   regs_q [NREG];
    logic [PEND_W-1:0] cnt_q  [NREG];
    logic [PEND_W-1:0] cnt_d  [NREG];
    logic              err_q;
    logic              err_d;

    logic [XLEN-1:0]   wb_data;
    logic              wr_eff;
    logic              wr_in_range;
    logic              wr_is_dram;
    logic [AW-1:0]     wr_idx;
    logic              dec_v;
    logic              iss_in_range;
    logic              iss_ok;
    logic [AW-1:0]     iss_idx;
    logic              inc_v;

    function automatic logic addr_in_range(input logic [4:0] a);
        return 32'(a) < NREG;
    endfunction

    // Writeback source mux; select 3 writes zero.
    always_comb begin
        wb_data = '0;
        case (rd_wr_sel_i)
            2'd0:    wb_data = alu_data_i;
            2'd1:    wb_data = dram_data_i;
            2'd2:    wb_data = pc_next_i;
            default: wb_data = '0;
        endcase
    end

    // Write / completion / issue qualification; nothing takes effect during reset.
    assign wr_in_range  = addr_in_range(rd_wr_addr_i);
    assign wr_idx       = AW'(rd_wr_addr_i);
    assign wr_eff       = !rst_i && rd_wr_en_i && (rd_wr_addr_i != 5'd0) && wr_in_range;
    assign wr_is_dram   = (rd_wr_sel_i == 2'd1);
    assign dec_v        = wr_eff && wr_is_dram && (cnt_q[wr_idx] != '0);

    assign iss_in_range = addr_in_range(issue_addr_i);
    assign iss_idx      = AW'(issue_addr_i);
    assign iss_ok       = iss_in_range && (issue_addr_i != 5'd0);
    assign issue_ready_o = rst_i || !iss_ok || (cnt_q[iss_idx] != CNT_MAX);
    assign inc_v        = !rst_i && issue_en_i && issue_ready_o && iss_ok;

    // Read ports with bypass and post-completion busy flag.
    for (genvar p = 0; p < int'(RD_PORTS); p++) begin : g_rd
        logic [4:0]        a;
        logic              valid;
        logic              hit;
        logic [PEND_W-1:0] dec_here;

        assign a        = rs_rd_addr_i[5*p +: 5];
        assign valid    = (a != 5'd0) && addr_in_range(a);
        assign hit      = wr_eff && (rd_wr_addr_i == a);
        assign dec_here = PEND_W'(dec_v && (rd_wr_addr_i == a));

        assign rs_rd_data_o[XLEN*p +: XLEN] = rst_i ? '0 :
                                              hit   ? wb_data :
                                              valid ? regs_q[AW'(a)] : '0;
        assign rs_busy_o[p] = !rst_i && valid && ((cnt_q[AW'(a)] - dec_here) != '0);
    end

    assign stall_o = |(rs_rd_en_i & rs_busy_o);

    // Pending counters: simultaneous issue and completion cancel out.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (inc_v && (iss_idx == AW'(r)) && !(dec_v && (wr_idx == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] + PEND_W'(1);
            end else if (dec_v && (wr_idx == AW'(r)) && !(inc_v && (iss_idx == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] - PEND_W'(1);
            end
        end
    end

    // Protocol errors: dropped issue, unmatched completion, out-of-range access.
    always_comb begin
        err_d = 1'b0;
        if (!rst_i) begin
            err_d = (issue_en_i && !issue_ready_o)
                 || (wr_eff && wr_is_dram && (cnt_q[wr_idx] == '0))
                 || (rd_wr_en_i && !wr_in_range)
                 || (issue_en_i && !iss_in_range);
        end
    end

    // State update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (wr_eff) begin
                regs_q[wr_idx] <= wb_data;
            end
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_idu_regfile_sb.sv
// Testbench for idu_regfile_sb (NREG=16, two read ports, 2-bit pending counters).
// Expected values are queued when stimulus is driven and popped when observed.
module tb_idu_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  busy;
    logic        stall;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [4:0]  wr_addr;
    logic [31:0] alu, dram, pcn;
    logic        err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp;

    always #5 clk = ~clk;

    idu_regfile_sb #(.XLEN(32), .NREG(16), .RD_PORTS(2), .PEND_W(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs_rd_en_i(rd_en), .rs_rd_addr_i(rd_addr), .rs_rd_data_o(rd_data),
        .rs_busy_o(busy), .stall_o(stall),
        .issue_en_i(iss_en), .issue_addr_i(iss_addr), .issue_ready_o(iss_ready),
        .rd_wr_en_i(wr_en), .rd_wr_sel_i(wr_sel), .rd_wr_addr_i(wr_addr),
        .alu_data_i(alu), .dram_data_i(dram), .pc_next_i(pcn),
        .err_o(err)
    );

    // Drive all inputs to an idle cycle at the next falling edge.
    task automatic idle_at_negedge();
        @(negedge clk);
        rst = 1'b0; rd_en = '0; rd_addr = '0; iss_en = 1'b0; iss_addr = '0;
        wr_en = 1'b0; wr_sel = '0; wr_addr = '0;
        alu = 32'h1111_1111; dram = 32'h2222_2222; pcn = 32'h3333_3333;
    endtask

    task automatic test_reset();
        idle_at_negedge();
        rst = 1'b1; rd_addr = {5'd5, 5'd5}; rd_en = 2'b11;
        wr_en = 1'b1; wr_addr = 5'd5; iss_en = 1'b1; iss_addr = 5'd5;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(rd_data[31:0]) !== exp) begin n_err++; $display("FAIL rst_rd_data got=%h exp=%h", rd_data[31:0], exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'({busy, stall}) !== exp) begin n_err++; $display("FAIL rst_busy_stall got=%h exp=%h", {busy, stall}, exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'(iss_ready) !== exp) begin n_err++; $display("FAIL rst_issue_ready got=%h exp=%h", iss_ready, exp); end
        idle_at_negedge();
        rst = 1'b1;
        idle_at_negedge();
        rd_addr = {5'd5, 5'd5}; rd_en = 2'b01;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL rst_err got=%h exp=%h", err, exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'(rd_data[31:0]) !== exp) begin n_err++; $display("FAIL rst_x5_not_written got=%h exp=%h", rd_data[31:0], exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'(stall) !== exp) begin n_err++; $display("FAIL rst_x5_no_pending got=%h exp=%h", stall, exp); end
    endtask

    task automatic test_write_read();
        idle_at_negedge();
        wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 5'd5; alu = 32'hDEAD_BEEF;
        idle_at_negedge();
        wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 5'd0; alu = 32'h5555_AAAA;
        rd_addr = {5'd5, 5'd5};
        exp_q.push_back(32'hDEAD_BEEF); exp_q.push_back(32'hDEAD_BEEF);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL rd_x5_p0 got=%h exp=%h", rd_data[31:0], exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[63:32] !== exp) begin n_err++; $display("FAIL rd_x5_p1 got=%h exp=%h", rd_data[63:32], exp); end
        idle_at_negedge();
        rd_addr = {5'd5, 5'd0};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL rd_x0 got=%h exp=%h", rd_data[31:0], exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL wr_x0_err got=%h exp=%h", err, exp); end
    endtask

    task automatic test_bypass();
        idle_at_negedge();
        wr_en = 1'b1; wr_sel = 2'd2; wr_addr = 5'd7; pcn = 32'h1234_5678; alu = 32'hBAD0_0000;
        rd_addr = {5'd7, 5'd5};
        exp_q.push_back(32'h1234_5678); exp_q.push_back(32'hDEAD_BEEF);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (rd_data[63:32] !== exp) begin n_err++; $display("FAIL bypass_x7_p1 got=%h exp=%h", rd_data[63:32], exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL nobypass_x5_p0 got=%h exp=%h", rd_data[31:0], exp); end
        idle_at_negedge();
        wr_en = 1'b1; wr_sel = 2'd3; wr_addr = 5'd8;
        rd_addr = {5'd7, 5'd8};
        exp_q.push_back(32'h0); exp_q.push_back(32'h1234_5678);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL bypass_sel3_x8 got=%h exp=%h", rd_data[31:0], exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[63:32] !== exp) begin n_err++; $display("FAIL stored_x7 got=%h exp=%h", rd_data[63:32], exp); end
    endtask

    task automatic test_scoreboard();
        idle_at_negedge();
        iss_en = 1'b1; iss_addr = 5'd3;
        exp_q.push_back(32'h1);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(iss_ready) !== exp) begin n_err++; $display("FAIL sb_issue_ready got=%h exp=%h", iss_ready, exp); end
        idle_at_negedge();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        exp_q.push_back(32'h1); exp_q.push_back(32'h1);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(busy[0]) !== exp) begin n_err++; $display("FAIL sb_busy_x3 got=%h exp=%h", busy[0], exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'(stall) !== exp) begin n_err++; $display("FAIL sb_stall_x3 got=%h exp=%h", stall, exp); end
        idle_at_negedge();
        rd_en = 2'b00; rd_addr = {5'd0, 5'd3};
        exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(stall) !== exp) begin n_err++; $display("FAIL sb_stall_unused got=%h exp=%h", stall, exp); end
        idle_at_negedge();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 5'd3; dram = 32'hA5A5_A5A5;
        exp_q.push_back(32'h0); exp_q.push_back(32'hA5A5_A5A5);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'({busy[0], stall}) !== exp) begin n_err++; $display("FAIL sb_complete_busy_stall got=%h exp=%h", {busy[0], stall}, exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL sb_complete_data got=%h exp=%h", rd_data[31:0], exp); end
        idle_at_negedge();
        rd_addr = {5'd0, 5'd3};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL sb_complete_err got=%h exp=%h", err, exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'(busy[0]) !== exp) begin n_err++; $display("FAIL sb_after_busy got=%h exp=%h", busy[0], exp); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            idle_at_negedge();
            iss_en = 1'b1; iss_addr = 5'd9;
            exp_q.push_back(32'h1);
            #1;
            n_vec++; exp = exp_q.pop_front(); if (32'(iss_ready) !== exp) begin n_err++; $display("FAIL sat_ready_%0d got=%h exp=%h", i, iss_ready, exp); end
        end
        idle_at_negedge();
        iss_en = 1'b1; iss_addr = 5'd9;
        exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(iss_ready) !== exp) begin n_err++; $display("FAIL sat_not_ready got=%h exp=%h", iss_ready, exp); end
        idle_at_negedge();
        exp_q.push_back(32'h1);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL sat_drop_err got=%h exp=%h", err, exp); end
        // Busy stays up through the first two completions, drops with the third.
        for (int i = 0; i < 3; i++) begin
            idle_at_negedge();
            rd_addr = {5'd0, 5'd9}; iss_addr = 5'd9;
            wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 5'd9; dram = 32'h9000_0000 + 32'(i);
            exp_q.push_back((i < 2) ? 32'h1 : 32'h0);
            exp_q.push_back((i == 0) ? 32'h0 : 32'h1);
            #1;
            n_vec++; exp = exp_q.pop_front(); if (32'(busy[0]) !== exp) begin n_err++; $display("FAIL sat_busy_%0d got=%h exp=%h", i, busy[0], exp); end
            n_vec++; exp = exp_q.pop_front(); if (32'(iss_ready) !== exp) begin n_err++; $display("FAIL sat_drain_ready_%0d got=%h exp=%h", i, iss_ready, exp); end
        end
        idle_at_negedge();
        rd_addr = {5'd0, 5'd9};
        exp_q.push_back(32'h0); exp_q.push_back(32'h9000_0002);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL sat_drain_err got=%h exp=%h", err, exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL sat_final_data got=%h exp=%h", rd_data[31:0], exp); end
    endtask

    task automatic test_same_cycle();
        idle_at_negedge();
        iss_en = 1'b1; iss_addr = 5'd4;
        idle_at_negedge();
        iss_en = 1'b1; iss_addr = 5'd4;
        wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 5'd4; dram = 32'h4444_0001;
        idle_at_negedge();
        rd_addr = {5'd4, 5'd4};
        exp_q.push_back(32'h3); exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(busy) !== exp) begin n_err++; $display("FAIL same_busy got=%h exp=%h", busy, exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL same_err got=%h exp=%h", err, exp); end
        idle_at_negedge();
        wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 5'd4; dram = 32'h4444_0002;
        idle_at_negedge();
        wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 5'd6; dram = 32'hCAFE_F00D;
        idle_at_negedge();
        rd_addr = {5'd4, 5'd6};
        exp_q.push_back(32'h1); exp_q.push_back(32'hCAFE_F00D); exp_q.push_back(32'h4444_0002);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL idle_dram_err got=%h exp=%h", err, exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL idle_dram_data got=%h exp=%h", rd_data[31:0], exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[63:32] !== exp) begin n_err++; $display("FAIL x4_drained_data got=%h exp=%h", rd_data[63:32], exp); end
        idle_at_negedge();
        exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL err_one_cycle got=%h exp=%h", err, exp); end
    endtask

    task automatic test_out_of_range();
        idle_at_negedge();
        wr_en = 1'b1; wr_sel = 2'd0; wr_addr = 5'd20; alu = 32'h2020_2020;
        rd_addr = {5'd20, 5'd4};
        exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (rd_data[63:32] !== exp) begin n_err++; $display("FAIL oor_no_bypass got=%h exp=%h", rd_data[63:32], exp); end
        idle_at_negedge();
        iss_en = 1'b1; iss_addr = 5'd20; rd_addr = {5'd20, 5'd20}; rd_en = 2'b11;
        exp_q.push_back(32'h1); exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL oor_wr_err got=%h exp=%h", err, exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL oor_rd_x20 got=%h exp=%h", rd_data[31:0], exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'(iss_ready) !== exp) begin n_err++; $display("FAIL oor_issue_ready got=%h exp=%h", iss_ready, exp); end
        idle_at_negedge();
        rd_addr = {5'd20, 5'd20}; rd_en = 2'b11;
        exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL oor_iss_err got=%h exp=%h", err, exp); end
        n_vec++; exp = exp_q.pop_front(); if (32'({busy, stall}) !== exp) begin n_err++; $display("FAIL oor_busy got=%h exp=%h", {busy, stall}, exp); end
    endtask

    task automatic test_reset_mid();
        idle_at_negedge();
        iss_en = 1'b1; iss_addr = 5'd3;
        idle_at_negedge();
        rd_en = 2'b01; rd_addr = {5'd5, 5'd3};
        exp_q.push_back(32'h1);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(stall) !== exp) begin n_err++; $display("FAIL mid_pre_stall got=%h exp=%h", stall, exp); end
        idle_at_negedge();
        rst = 1'b1; rd_en = 2'b11; rd_addr = {5'd5, 5'd3};
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'({busy, stall}) !== exp) begin n_err++; $display("FAIL mid_rst_busy got=%h exp=%h", {busy, stall}, exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[63:32] !== exp) begin n_err++; $display("FAIL mid_rst_rd_x5 got=%h exp=%h", rd_data[63:32], exp); end
        idle_at_negedge();
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        wr_en = 1'b1; wr_sel = 2'd1; wr_addr = 5'd3; dram = 32'h0000_0077;
        exp_q.push_back(32'h0);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(stall) !== exp) begin n_err++; $display("FAIL mid_post_stall got=%h exp=%h", stall, exp); end
        idle_at_negedge();
        rd_addr = {5'd0, 5'd3};
        exp_q.push_back(32'h1); exp_q.push_back(32'h0000_0077);
        #1;
        n_vec++; exp = exp_q.pop_front(); if (32'(err) !== exp) begin n_err++; $display("FAIL mid_late_err got=%h exp=%h", err, exp); end
        n_vec++; exp = exp_q.pop_front(); if (rd_data[31:0] !== exp) begin n_err++; $display("FAIL mid_late_data got=%h exp=%h", rd_data[31:0], exp); end
    endtask

    initial begin
        rst = 1'b1; rd_en = '0; rd_addr = '0; iss_en = 1'b0; iss_addr = '0;
        wr_en = 1'b0; wr_sel = '0; wr_addr = '0; alu = '0; dram = '0; pcn = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_saturation();
        test_same_cycle();
        test_out_of_range();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
